// File: rtl/foo_quux_fifo.sv
// foo_quux_fifo: valid/ready buffering stage ahead of the Foo.quux consumer.
// Holds up to DEPTH words in strict FIFO order, with a minimum latency of one cycle.
// Optional build macro FOO_QUUX_FIFO_BYPASS_EN: while the stage is empty, an
// incoming word is presented to the consumer in the same cycle (zero latency).
module foo_quux_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty    = (count == '0);
    assign in_ready = (count != CW'(DEPTH));

`ifdef FOO_QUUX_FIFO_BYPASS_EN
    assign bypass = empty & in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~empty | bypass;

    // Gate the output so that unreset storage never shows through while empty.
    always_comb begin
        out_data = '0;
        if (!empty) begin
            out_data = mem[rd_ptr];
        end else if (bypass) begin
            out_data = in_data;
        end
    end

    // A word handed straight through in bypass is neither stored nor counted.
    assign push = in_valid & in_ready & ~(bypass & out_ready);
    assign pop  = ~empty & out_ready;

    // Storage write; contents are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; reset drops all buffered words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
